// File: rtl/design_1_wrapper.sv
// Two-stage fetch/decode front end (PC + ROM -> IF/ID -> decode -> ID/EXE) for an ARM-like core.
// Optional feature: define COND_CHECK_EN to evaluate the condition field against a fixed NZCV.
module design_1_wrapper (
  input  logic        clk_0,
  input  logic        rst_0,
  output logic [31:0] pc_out_0,
  output logic [3:0]  exe_cmd_out_0,
  output logic        mem_read_out_0,
  output logic        mem_write_out_0,
  output logic        wb_enable_out_0,
  output logic        branch_taken_out_0,
  output logic        status_update_out_0,
  output logic        imm_out_0,
  output logic [3:0]  dest_reg_out_0,
  output logic [3:0]  src1_out_0,
  output logic [3:0]  src2_out_0,
  output logic [31:0] val_rn_out_0,
  output logic [31:0] val_rm_out_0,
  output logic [11:0] shift_operand_out_0,
  output logic [23:0] signed_imm_24_out_0
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 16;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] rf [NREG];

  logic [3:0] d_cmd;
  logic       d_mr, d_mw, d_wb, d_br, d_s, d_valid, cond_pass;
  logic [3:0] d_src1, d_src2;

  // Instruction ROM, word-indexed by PC[7:2]
  function automatic logic [31:0] rom_word(input logic [5:0] idx);
    case (idx)
      6'd0:    rom_word = 32'hE3A01014;
      6'd1:    rom_word = 32'hE0832001;
      6'd2:    rom_word = 32'hE1530002;
      6'd3:    rom_word = 32'hE5942008;
      6'd4:    rom_word = 32'hE5842008;
      6'd5:    rom_word = 32'hEAFFFFFE;
      6'd6:    rom_word = 32'h03A05005;
      default: rom_word = 32'h00000000;
    endcase
  endfunction

`ifdef COND_CHECK_EN
  logic [3:0] nzcv;

  always_ff @(posedge clk_0) begin
    if (rst_0) nzcv <= 4'b0000;
  end

  // Standard ARM condition evaluation; NV (1111) never executes
  always_comb begin
    cond_pass = 1'b0;
    case (if_instr[31:28])
      4'h0: cond_pass = nzcv[2];
      4'h1: cond_pass = !nzcv[2];
      4'h2: cond_pass = nzcv[1];
      4'h3: cond_pass = !nzcv[1];
      4'h4: cond_pass = nzcv[3];
      4'h5: cond_pass = !nzcv[3];
      4'h6: cond_pass = nzcv[0];
      4'h7: cond_pass = !nzcv[0];
      4'h8: cond_pass = nzcv[1] && !nzcv[2];
      4'h9: cond_pass = !nzcv[1] || nzcv[2];
      4'hA: cond_pass = (nzcv[3] == nzcv[0]);
      4'hB: cond_pass = (nzcv[3] != nzcv[0]);
      4'hC: cond_pass = !nzcv[2] && (nzcv[3] == nzcv[0]);
      4'hD: cond_pass = nzcv[2] || (nzcv[3] != nzcv[0]);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^if_instr[31:28];
  assign cond_pass   = 1'b1;
`endif

  // Decode: control fields are squashed when the encoding is undefined or the condition fails
  always_comb begin
    d_cmd   = 4'b0000;
    d_mr    = 1'b0;
    d_mw    = 1'b0;
    d_wb    = 1'b0;
    d_br    = 1'b0;
    d_s     = 1'b0;
    d_valid = 1'b0;
    case (if_instr[27:26])
      2'b00: begin
        d_valid = 1'b1;
        d_wb    = 1'b1;
        d_s     = if_instr[20];
        case (if_instr[24:21])
          4'b1101: d_cmd = 4'b0001;
          4'b1111: d_cmd = 4'b1001;
          4'b0100: d_cmd = 4'b0010;
          4'b0101: d_cmd = 4'b0011;
          4'b0010: d_cmd = 4'b0100;
          4'b0110: d_cmd = 4'b0101;
          4'b0000: d_cmd = 4'b0110;
          4'b1100: d_cmd = 4'b0111;
          4'b0001: d_cmd = 4'b1000;
          4'b1010: begin d_cmd = 4'b0100; d_wb = 1'b0; end
          4'b1000: begin d_cmd = 4'b0110; d_wb = 1'b0; end
          default: d_valid = 1'b0;
        endcase
      end
      2'b01: begin
        d_valid = 1'b1;
        d_cmd   = 4'b0010;
        if (if_instr[20]) begin
          d_mr = 1'b1;
          d_wb = 1'b1;
        end else begin
          d_mw = 1'b1;
        end
      end
      2'b10: begin
        if (if_instr[25]) begin
          d_valid = 1'b1;
          d_br    = 1'b1;
        end
      end
      default: d_valid = 1'b0;
    endcase
    if (!d_valid || !cond_pass) begin
      d_cmd = 4'b0000;
      d_mr  = 1'b0;
      d_mw  = 1'b0;
      d_wb  = 1'b0;
      d_br  = 1'b0;
      d_s   = 1'b0;
    end
  end

  assign d_src1 = if_instr[19:16];
  assign d_src2 = (if_instr[27:26] == 2'b01 && !if_instr[20]) ? if_instr[15:12] : if_instr[3:0];

  // PC, IF/ID, register file and ID/EXE registers
  always_ff @(posedge clk_0) begin
    if (rst_0) begin
      pc                  <= '0;
      if_pc               <= '0;
      if_instr            <= '0;
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= XLEN'(i);
      pc_out_0            <= '0;
      exe_cmd_out_0       <= '0;
      mem_read_out_0      <= 1'b0;
      mem_write_out_0     <= 1'b0;
      wb_enable_out_0     <= 1'b0;
      branch_taken_out_0  <= 1'b0;
      status_update_out_0 <= 1'b0;
      imm_out_0           <= 1'b0;
      dest_reg_out_0      <= '0;
      src1_out_0          <= '0;
      src2_out_0          <= '0;
      val_rn_out_0        <= '0;
      val_rm_out_0        <= '0;
      shift_operand_out_0 <= '0;
      signed_imm_24_out_0 <= '0;
    end else begin
      pc                  <= pc + XLEN'(4);
      if_pc               <= pc + XLEN'(4);
      if_instr            <= rom_word(pc[7:2]);
      pc_out_0            <= if_pc;
      exe_cmd_out_0       <= d_cmd;
      mem_read_out_0      <= d_mr;
      mem_write_out_0     <= d_mw;
      wb_enable_out_0     <= d_wb;
      branch_taken_out_0  <= d_br;
      status_update_out_0 <= d_s;
      imm_out_0           <= if_instr[25];
      dest_reg_out_0      <= if_instr[15:12];
      src1_out_0          <= d_src1;
      src2_out_0          <= d_src2;
      val_rn_out_0        <= rf[d_src1];
      val_rm_out_0        <= rf[d_src2];
      shift_operand_out_0 <= if_instr[11:0];
      signed_imm_24_out_0 <= if_instr[23:0];
    end
  end

endmodule

// File: tb/tb_design_1_wrapper.sv
// Self-checking bench for design_1_wrapper: directed program checks plus randomized run/reset
// sequences compared against a cycle-count based reference model.
module tb_design_1_wrapper;

  logic        clk_0 = 1'b0;
  logic        rst_0 = 1'b1;
  logic [31:0] pc_out_0;
  logic [3:0]  exe_cmd_out_0;
  logic        mem_read_out_0, mem_write_out_0, wb_enable_out_0;
  logic        branch_taken_out_0, status_update_out_0, imm_out_0;
  logic [3:0]  dest_reg_out_0, src1_out_0, src2_out_0;
  logic [31:0] val_rn_out_0, val_rm_out_0;
  logic [11:0] shift_operand_out_0;
  logic [23:0] signed_imm_24_out_0;

  design_1_wrapper dut (
    .clk_0(clk_0), .rst_0(rst_0),
    .pc_out_0(pc_out_0), .exe_cmd_out_0(exe_cmd_out_0),
    .mem_read_out_0(mem_read_out_0), .mem_write_out_0(mem_write_out_0),
    .wb_enable_out_0(wb_enable_out_0), .branch_taken_out_0(branch_taken_out_0),
    .status_update_out_0(status_update_out_0), .imm_out_0(imm_out_0),
    .dest_reg_out_0(dest_reg_out_0), .src1_out_0(src1_out_0), .src2_out_0(src2_out_0),
    .val_rn_out_0(val_rn_out_0), .val_rm_out_0(val_rm_out_0),
    .shift_operand_out_0(shift_operand_out_0), .signed_imm_24_out_0(signed_imm_24_out_0)
  );

  always #5 clk_0 = ~clk_0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;   // edges since reset release
  logic [31:0] rom [64];
  int          dp_cmd [16];

  logic [153:0] act;
  assign act = {pc_out_0, exe_cmd_out_0, mem_read_out_0, mem_write_out_0, wb_enable_out_0,
                branch_taken_out_0, status_update_out_0, imm_out_0, dest_reg_out_0,
                src1_out_0, src2_out_0, val_rn_out_0, val_rm_out_0,
                shift_operand_out_0, signed_imm_24_out_0};

  // Condition check with the architectural flags all clear
  function automatic bit cond_ok(input logic [3:0] cond);
    bit n = 0, z = 0, c = 0, v = 0;
    bit base;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: return cond == 4'hE;
    endcase
    return cond[0] ? !base : base;
  endfunction

  // Expected output vector n edges after reset release (n=0: in reset)
  function automatic logic [153:0] model_out(input int unsigned n);
    logic [31:0] instr, pc;
    logic [3:0]  cmd, src2;
    bit          mr = 0, mw = 0, wb = 0, br = 0, s = 0, ok = 0;
    if (n == 0) return '0;
    pc    = 32'(4 * (n - 1));
    instr = (n == 1) ? 32'h0 : rom[(n - 2) % 64];
    cmd   = 4'h0;
    if (instr[27:26] == 2'b00 && dp_cmd[instr[24:21]] >= 0) begin
      ok  = 1;
      cmd = 4'(dp_cmd[instr[24:21]]);
      wb  = !(instr[24:21] == 4'hA || instr[24:21] == 4'h8);
      s   = instr[20];
    end else if (instr[27:26] == 2'b01) begin
      ok  = 1;
      cmd = 4'h2;
      mr  = instr[20];
      wb  = instr[20];
      mw  = !instr[20];
    end else if (instr[27:25] == 3'b101) begin
      ok = 1;
      br = 1;
    end
`ifdef COND_CHECK_EN
    if (!cond_ok(instr[31:28])) ok = 0;
`endif
    if (!ok) begin
      cmd = 0; mr = 0; mw = 0; wb = 0; br = 0; s = 0;
    end
    src2 = (instr[27:26] == 2'b01 && !instr[20]) ? instr[15:12] : instr[3:0];
    return {pc, cmd, mr, mw, wb, br, s, instr[25], instr[15:12], instr[19:16], src2,
            32'(instr[19:16]), 32'(src2), instr[11:0], instr[23:0]};
  endfunction

  task automatic tick();
    @(posedge clk_0);
    #1;
    if (rst_0) cyc = 0;
    else cyc++;
  endtask

  task automatic test_reset();
    rst_0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (act !== '0) begin
        errors++;
        $display("FAIL reset_zero edge=%0d act=%h exp=0", i, act);
      end
    end
  endtask

  task automatic test_program();
    logic [153:0] exp;
    rst_0 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = model_out(cyc);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL prog_model n=%0d act=%h exp=%h", cyc, act, exp);
      end
      checks++;
      case (k)
        2: if ({pc_out_0, exe_cmd_out_0, imm_out_0, wb_enable_out_0, dest_reg_out_0, shift_operand_out_0}
               !== {32'h4, 4'h1, 1'b1, 1'b1, 4'h1, 12'h014}) begin
             errors++; $display("FAIL prog_mov pc=%h cmd=%h exp pc=4 cmd=1", pc_out_0, exe_cmd_out_0);
           end
        3: if ({pc_out_0, exe_cmd_out_0, src1_out_0, val_rn_out_0, src2_out_0, val_rm_out_0, dest_reg_out_0, status_update_out_0}
               !== {32'h8, 4'h2, 4'h3, 32'h3, 4'h1, 32'h1, 4'h2, 1'b0}) begin
             errors++; $display("FAIL prog_add pc=%h cmd=%h exp pc=8 cmd=2", pc_out_0, exe_cmd_out_0);
           end
        4: if ({exe_cmd_out_0, status_update_out_0, wb_enable_out_0} !== {4'h4, 1'b1, 1'b0}) begin
             errors++; $display("FAIL prog_cmp cmd=%h s=%b wb=%b exp 4/1/0", exe_cmd_out_0, status_update_out_0, wb_enable_out_0);
           end
        5: if ({mem_read_out_0, wb_enable_out_0, src1_out_0, val_rn_out_0} !== {1'b1, 1'b1, 4'h4, 32'h4}) begin
             errors++; $display("FAIL prog_ldr mr=%b wb=%b rn=%h exp 1/1/4", mem_read_out_0, wb_enable_out_0, val_rn_out_0);
           end
        6: if ({mem_write_out_0, src2_out_0, val_rm_out_0} !== {1'b1, 4'h2, 32'h2}) begin
             errors++; $display("FAIL prog_str mw=%b src2=%h rm=%h exp 1/2/2", mem_write_out_0, src2_out_0, val_rm_out_0);
           end
        7: if ({branch_taken_out_0, signed_imm_24_out_0} !== {1'b1, 24'hFFFFFE}) begin
             errors++; $display("FAIL prog_b br=%b imm=%h exp 1/fffffe", branch_taken_out_0, signed_imm_24_out_0);
           end
`ifdef COND_CHECK_EN
        8: if ({pc_out_0, exe_cmd_out_0, mem_read_out_0, mem_write_out_0, wb_enable_out_0, branch_taken_out_0, status_update_out_0, dest_reg_out_0}
               !== {32'h1C, 4'h0, 5'b00000, 4'h5}) begin
             errors++; $display("FAIL prog_moveq cmd=%h wb=%b dest=%h exp 0/0/5", exe_cmd_out_0, wb_enable_out_0, dest_reg_out_0);
           end
`else
        8: if ({pc_out_0, exe_cmd_out_0, wb_enable_out_0, dest_reg_out_0} !== {32'h1C, 4'h1, 1'b1, 4'h5}) begin
             errors++; $display("FAIL prog_moveq cmd=%h wb=%b dest=%h exp 1/1/5", exe_cmd_out_0, wb_enable_out_0, dest_reg_out_0);
           end
`endif
        default: if (pc_out_0 !== 32'(4 * (k - 1))) begin
             errors++; $display("FAIL prog_pc act=%h exp=%h", pc_out_0, 32'(4 * (k - 1)));
           end
      endcase
    end
  endtask

  task automatic test_mid_reset();
    int unsigned budget = 0;
    rst_0 = 1'b1;
    tick();
    rst_0 = 1'b0;
    while (pc_out_0 !== 32'h10 && budget < 100) begin
      tick();
      budget++;
    end
    checks++;
    if (pc_out_0 !== 32'h10) begin
      errors++;
      $display("FAIL mid_reset_wait pc=%h exp=00000010", pc_out_0);
    end
    rst_0 = 1'b1;
    tick();
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL mid_reset_zero act=%h exp=0", act);
    end
    rst_0 = 1'b0;
    tick();
    tick();
    checks++;
    if ({pc_out_0, exe_cmd_out_0, imm_out_0, wb_enable_out_0, dest_reg_out_0, shift_operand_out_0}
        !== {32'h4, 4'h1, 1'b1, 1'b1, 4'h1, 12'h014}) begin
      errors++;
      $display("FAIL mid_reset_restart pc=%h cmd=%h exp pc=4 cmd=1", pc_out_0, exe_cmd_out_0);
    end
  endtask

  task automatic test_random();
    logic [153:0] exp;
    int unsigned  run, hold;
    for (int it = 0; it < 20; it++) begin
      run  = $urandom_range(90, 1);
      hold = $urandom_range(3, 1);
      rst_0 = 1'b0;
      for (int unsigned k = 0; k < run; k++) begin
        tick();
        exp = model_out(cyc);
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL rand_run it=%0d n=%0d act=%h exp=%h", it, cyc, act, exp);
        end
      end
      rst_0 = 1'b1;
      for (int unsigned k = 0; k < hold; k++) begin
        tick();
        checks++;
        if (act !== '0) begin
          errors++;
          $display("FAIL rand_reset it=%0d act=%h exp=0", it, act);
        end
      end
    end
    rst_0 = 1'b0;
  endtask

  initial begin
    foreach (rom[i]) rom[i] = 32'h0;
    rom[0] = 32'hE3A01014; rom[1] = 32'hE0832001; rom[2] = 32'hE1530002;
    rom[3] = 32'hE5942008; rom[4] = 32'hE5842008; rom[5] = 32'hEAFFFFFE;
    rom[6] = 32'h03A05005;
    dp_cmd = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

    test_reset();
    test_program();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
